// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / stall controller.
//   state_e    : sequencer state (RUN=0, MEM_WAIT=1)
//   REG_IDX_W  : width of an architectural register index
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard comparator. Flags when the instruction in EX is a load
// whose destination is read by the instruction in ID. x0 never hazards.
//   mem_read_i      : EX-stage instruction is a load
//   rd_i            : EX-stage destination register
//   rs1_i / rs2_i   : ID-stage source registers
//   use_rs1_i/_rs2_i: ID-stage instruction actually reads that source
//   lu_haz_o        : load-use hazard present
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 mem_read_i,
    input  logic [REG_IDX_W-1:0] rd_i,
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    input  logic                 use_rs1_i,
    input  logic                 use_rs2_i,
    output logic                 lu_haz_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = use_rs1_i && (rd_i == rs1_i);
    assign rs2_hit  = use_rs2_i && (rd_i == rs2_i);
    assign lu_haz_o = mem_read_i && (rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for a 5-stage pipeline.
// Priority in RUN: (1) data-memory wait, (2) taken branch, (3) load-use.
// Ports:
//   clk, rst                    : clock, async active-high reset
//   Mem_Read_ID_EX, rd_ID_EX    : EX-stage load and its destination
//   rs1_IF_ID, rs2_IF_ID,
//   use_rs1, use_rs2            : ID-stage sources and their use flags
//   PcSrc_EX_MEM, zero_EX_MEM   : MEM-stage branch and condition
//   Mem_Read/Write_EX_MEM       : MEM-stage memory access
//   dmem_ready                  : memory finishes the access this cycle
//   pc_en..mem_wb_flush         : pipeline register enables / clears
//   dmem_req, dmem_abort        : memory request, one-cycle abort on timeout
//   mem_err                     : sticky timeout flag
//   stall_cnt                   : saturating count of cycles with pc_en=0
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Mem_Read_ID_EX,
    input  logic [REG_IDX_W-1:0] rd_ID_EX,
    input  logic [REG_IDX_W-1:0] rs1_IF_ID,
    input  logic [REG_IDX_W-1:0] rs2_IF_ID,
    input  logic                 use_rs1,
    input  logic                 use_rs2,
    input  logic                 PcSrc_EX_MEM,
    input  logic                 zero_EX_MEM,
    input  logic                 Mem_Read_EX_MEM,
    input  logic                 Mem_Write_EX_MEM,
    input  logic                 dmem_ready,
    output logic                 pc_en,
    output logic                 pc_sel,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic                 id_ex_en,
    output logic                 id_ex_flush,
    output logic                 ex_mem_en,
    output logic                 ex_mem_flush,
    output logic                 mem_wb_flush,
    output logic                 dmem_req,
    output logic                 dmem_abort,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     stall_cnt
);

    // wait_cnt only ever holds 0..MEM_TIMEOUT-1
    localparam int                WC_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0]   WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_e            state_q,     state_d;
    logic [WC_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic              mem_err_q,   mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic mem_op, br_taken, lu_haz;
    logic eval_br_lu;   // memory side is not holding the pipe this cycle

    logic pc_en_c, pc_sel_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_flush_c;
    logic ex_mem_en_c, ex_mem_flush_c, mem_wb_flush_c, dmem_req_c, dmem_abort_c;

    assign mem_op   = Mem_Read_EX_MEM | Mem_Write_EX_MEM;
    assign br_taken = PcSrc_EX_MEM & zero_EX_MEM;

    hazard_detect u_hazard_detect (
        .mem_read_i (Mem_Read_ID_EX),
        .rd_i       (rd_ID_EX),
        .rs1_i      (rs1_IF_ID),
        .rs2_i      (rs2_IF_ID),
        .use_rs1_i  (use_rs1),
        .use_rs2_i  (use_rs2),
        .lu_haz_o   (lu_haz)
    );

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_err_d      = mem_err_q;
        eval_br_lu     = 1'b0;
        pc_en_c        = 1'b1;
        pc_sel_c       = 1'b0;
        if_id_en_c     = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_en_c     = 1'b1;
        id_ex_flush_c  = 1'b0;
        ex_mem_en_c    = 1'b1;
        ex_mem_flush_c = 1'b0;
        mem_wb_flush_c = 1'b0;
        dmem_req_c     = 1'b0;
        dmem_abort_c   = 1'b0;

        case (state_q)
            RUN: begin
                dmem_req_c = mem_op;
                if (mem_op && !dmem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end else begin
                    eval_br_lu = 1'b1;
                end
            end
            MEM_WAIT: begin
                dmem_req_c = 1'b1;
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    eval_br_lu = 1'b1;
                end else if (wait_cnt_q == WC_LAST) begin
                    // Give up: release the pipe as though the access finished.
                    dmem_abort_c = 1'b1;
                    mem_err_d    = 1'b1;
                    state_d      = RUN;
                    wait_cnt_d   = '0;
                    eval_br_lu   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (!eval_br_lu) begin
            // Whole pipe frozen; bubble into MEM/WB so WB does not repeat.
            pc_en_c        = 1'b0;
            if_id_en_c     = 1'b0;
            id_ex_en_c     = 1'b0;
            ex_mem_en_c    = 1'b0;
            mem_wb_flush_c = 1'b1;
        end else if (br_taken) begin
            // Squashing ID also removes any load-use hazard it carried.
            pc_sel_c       = 1'b1;
            if_id_flush_c  = 1'b1;
            id_ex_flush_c  = 1'b1;
            ex_mem_flush_c = 1'b1;
        end else if (lu_haz) begin
            pc_en_c       = 1'b0;
            if_id_en_c    = 1'b0;
            id_ex_flush_c = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_en_c && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational outputs are forced low for as long as reset is held.
    assign pc_en        = !rst && pc_en_c;
    assign pc_sel       = !rst && pc_sel_c;
    assign if_id_en     = !rst && if_id_en_c;
    assign if_id_flush  = !rst && if_id_flush_c;
    assign id_ex_en     = !rst && id_ex_en_c;
    assign id_ex_flush  = !rst && id_ex_flush_c;
    assign ex_mem_en    = !rst && ex_mem_en_c;
    assign ex_mem_flush = !rst && ex_mem_flush_c;
    assign mem_wb_flush = !rst && mem_wb_flush_c;
    assign dmem_req     = !rst && dmem_req_c;
    assign dmem_abort   = !rst && dmem_abort_c;
    assign mem_err      = mem_err_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int MT    = 4;
    localparam int CW    = 6;
    localparam int SMAX  = (1 << CW) - 1;

    typedef struct packed {
        logic          pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
        logic          ex_mem_en, ex_mem_flush, mem_wb_flush, dmem_req, dmem_abort, mem_err;
        logic [CW-1:0] stall_cnt;
    } out_t;

    typedef struct packed {
        logic       mr;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, pcsrc, zero, mrd, mwr, rdy;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic       Mem_Read_ID_EX = 0, use_rs1 = 0, use_rs2 = 0, PcSrc_EX_MEM = 0, zero_EX_MEM = 0;
    logic       Mem_Read_EX_MEM = 0, Mem_Write_EX_MEM = 0, dmem_ready = 0;
    logic [4:0] rd_ID_EX = 0, rs1_IF_ID = 0, rs2_IF_ID = 0;
    logic pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic ex_mem_en, ex_mem_flush, mem_wb_flush, dmem_req, dmem_abort, mem_err;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Mem_Read_ID_EX(Mem_Read_ID_EX), .rd_ID_EX(rd_ID_EX),
        .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
        .use_rs1(use_rs1), .use_rs2(use_rs2),
        .PcSrc_EX_MEM(PcSrc_EX_MEM), .zero_EX_MEM(zero_EX_MEM),
        .Mem_Read_EX_MEM(Mem_Read_EX_MEM), .Mem_Write_EX_MEM(Mem_Write_EX_MEM),
        .dmem_ready(dmem_ready),
        .pc_en(pc_en), .pc_sel(pc_sel), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .dmem_req(dmem_req),
        .dmem_abort(dmem_abort), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    out_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model state: cycles already spent on the current memory
    // access, sticky error, and the number of cycles the PC has been held.
    int   m_acc    = 0;
    bit   m_err    = 0;
    int   m_stalls = 0;

    function automatic stim_t S(input logic mr, input logic [4:0] rd, rs1, rs2,
                                input logic u1, u2, pcsrc, zero, mrd, mwr, rdy);
        stim_t s;
        s = '{mr:mr, rd:rd, rs1:rs1, rs2:rs2, u1:u1, u2:u2, pcsrc:pcsrc,
              zero:zero, mrd:mrd, mwr:mwr, rdy:rdy};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        Mem_Read_ID_EX   = s.mr;    rd_ID_EX    = s.rd;
        rs1_IF_ID        = s.rs1;   rs2_IF_ID   = s.rs2;
        use_rs1          = s.u1;    use_rs2     = s.u2;
        PcSrc_EX_MEM     = s.pcsrc; zero_EX_MEM = s.zero;
        Mem_Read_EX_MEM  = s.mrd;   Mem_Write_EX_MEM = s.mwr;
        dmem_ready       = s.rdy;
    endtask

    // One clock of normal operation: drive, predict, enqueue, advance model.
    task automatic step(input stim_t s);
        out_t e;
        bit   mem_op, br, lu, active;
        int   k;
        @(posedge clk); #1;
        rst = 1'b0;
        apply(s);
        e = '0;
        mem_op = s.mrd || s.mwr;
        br     = s.pcsrc && s.zero;
        lu     = s.mr && (s.rd != 0) &&
                 ((s.u1 && s.rd == s.rs1) || (s.u2 && s.rd == s.rs2));
        active = (m_acc > 0) || mem_op;
        k      = m_acc + 1;
        e.dmem_req  = active;
        e.mem_err   = m_err;
        e.stall_cnt = CW'(m_stalls);
        if (active && !s.rdy && k < MT) begin
            e.mem_wb_flush = 1;
            m_acc = k;
        end else begin
            if (active && !s.rdy) begin
                e.dmem_abort = 1;
                m_err = 1;
            end
            m_acc = 0;
            e.pc_en = 1; e.if_id_en = 1; e.id_ex_en = 1; e.ex_mem_en = 1;
            if (br) begin
                e.pc_sel = 1; e.if_id_flush = 1; e.id_ex_flush = 1; e.ex_mem_flush = 1;
            end else if (lu) begin
                e.pc_en = 0; e.if_id_en = 0; e.id_ex_flush = 1;
            end
        end
        sb.push_back(e);
        if (!e.pc_en && m_stalls < SMAX) m_stalls++;
    endtask

    // Reset asserted between edges; optionally released before the next edge.
    task automatic reset_cycle(input bit hold);
        out_t e;
        @(posedge clk); #1;
        rst = 1'b1;
        apply('0);
        m_acc = 0; m_err = 0; m_stalls = 0;
        e = '0;
        sb.push_back(e);
        if (!hold) begin
            @(negedge clk); #2;
            rst = 1'b0;
        end
    endtask

    function automatic stim_t rnd(input bit stuck);
        stim_t s;
        s.mr    = 1'($urandom_range(0, 1));
        s.rd    = 5'($urandom_range(0, 3));
        s.rs1   = 5'($urandom_range(0, 3));
        s.rs2   = 5'($urandom_range(0, 3));
        s.u1    = 1'($urandom_range(0, 1));
        s.u2    = 1'($urandom_range(0, 1));
        s.pcsrc = ($urandom_range(0, 2) == 0);
        s.zero  = 1'($urandom_range(0, 1));
        s.mrd   = ($urandom_range(0, 5) == 0);
        s.mwr   = ($urandom_range(0, 5) == 0);
        s.rdy   = stuck ? 1'b0 : ($urandom_range(0, 2) == 0);
        return s;
    endfunction

    always @(negedge clk) begin
        out_t e, a;
        cyc++;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            a = '{pc_en:pc_en, pc_sel:pc_sel, if_id_en:if_id_en, if_id_flush:if_id_flush,
                  id_ex_en:id_ex_en, id_ex_flush:id_ex_flush, ex_mem_en:ex_mem_en,
                  ex_mem_flush:ex_mem_flush, mem_wb_flush:mem_wb_flush, dmem_req:dmem_req,
                  dmem_abort:dmem_abort, mem_err:mem_err, stall_cnt:stall_cnt};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL outputs @cyc %0d: got pcen=%b sel=%b ifen=%b iffl=%b idexen=%b idexfl=%b exen=%b exfl=%b wbfl=%b req=%b abt=%b err=%b cnt=%0d | want pcen=%b sel=%b ifen=%b iffl=%b idexen=%b idexfl=%b exen=%b exfl=%b wbfl=%b req=%b abt=%b err=%b cnt=%0d",
                         cyc, a.pc_en, a.pc_sel, a.if_id_en, a.if_id_flush, a.id_ex_en,
                         a.id_ex_flush, a.ex_mem_en, a.ex_mem_flush, a.mem_wb_flush,
                         a.dmem_req, a.dmem_abort, a.mem_err, a.stall_cnt,
                         e.pc_en, e.pc_sel, e.if_id_en, e.if_id_flush, e.id_ex_en,
                         e.id_ex_flush, e.ex_mem_en, e.ex_mem_flush, e.mem_wb_flush,
                         e.dmem_req, e.dmem_abort, e.mem_err, e.stall_cnt);
            end
        end
    end

    initial begin
        bit stuck;
        // Reset held from time 0: everything low.
        reset_cycle(1);
        reset_cycle(1);
        // Idle default.
        step(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Load-use: lw x5 in EX, ID reads x5 -> one bubble, then default.
        step(S(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0));
        step(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Hazard via rs2 only.
        step(S(1, 7, 1, 7, 0, 1, 0, 0, 0, 0, 0));
        // Same register but not used -> no stall.
        step(S(1, 7, 7, 7, 0, 0, 0, 0, 0, 0, 0));
        // x0 destination never hazards.
        step(S(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        // Taken branch wins over load-use.
        step(S(1, 5, 5, 0, 1, 0, 1, 1, 0, 0, 0));
        // Not-taken branch leaves the load-use stall in place.
        step(S(1, 5, 5, 0, 1, 0, 1, 0, 0, 0, 0));
        // Zero-wait access.
        step(S(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        // Ready without a request is ignored.
        step(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Three wait cycles then ready; branch acted on at release.
        repeat (3) step(S(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        step(S(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1));
        step(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Store never answered -> abort on the MT-th access cycle; error stays set.
        repeat (MT) step(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(S(1, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0));
        // Randomized traffic with occasional stuck-memory phases.
        stuck = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 40 == 0) stuck = ($urandom_range(0, 9) < 3);
            step(rnd(stuck));
        end
        // Reset pulse in the middle of a memory wait.
        step(S(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        step(S(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        reset_cycle(0);
        step(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(S(1, 2, 2, 0, 1, 0, 0, 0, 0, 0, 0));
        step(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        stuck = 0;
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) stuck = ($urandom_range(0, 9) < 3);
            step(rnd(stuck));
        end
        @(posedge clk);
        @(negedge clk); #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
